// File: rtl/rs_alu_issue.sv
// rs_alu_issue: ALU reservation station for the Tomasulo core.
// Holds dispatched micro-ops until both operands are available. It snoops the
// ALU and LSB result buses to capture pending operands, and each cycle sends
// the lowest-index ready entry to the ALU through registered outputs.
module rs_alu_issue #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_POS_W = 5,
    parameter int OPENUM_W  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 clr,
    input  logic                 issue_enable,
    input  logic [OPENUM_W-1:0]  issue_openum,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    input  logic [31:0]          issue_pc,
    input  logic [31:0]          issue_imm,
    input  logic                 issue_rs1_dep,
    input  logic [ROB_POS_W-1:0] issue_rs1_tag,
    input  logic [31:0]          issue_rs1_val,
    input  logic                 issue_rs2_dep,
    input  logic [ROB_POS_W-1:0] issue_rs2_tag,
    input  logic [31:0]          issue_rs2_val,
    output logic                 rs_full,
    input  logic                 alu_broadcast_enable,
    input  logic [ROB_POS_W-1:0] alu_broadcast_rob_pos,
    input  logic [31:0]          alu_broadcast_val,
    input  logic                 lsb_broadcast_enable,
    input  logic [ROB_POS_W-1:0] lsb_broadcast_rob_pos,
    input  logic [31:0]          lsb_broadcast_val,
    output logic                 rs_to_alu_enable,
    output logic [OPENUM_W-1:0]  rs_to_alu_openum,
    output logic [ROB_POS_W-1:0] rs_to_alu_rob_pos,
    output logic [31:0]          rs_to_alu_rs1_val,
    output logic [31:0]          rs_to_alu_rs2_val,
    output logic [31:0]          rs_to_alu_imm,
    output logic [31:0]          rs_to_alu_pc
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic                 busy;
        logic [OPENUM_W-1:0]  openum;
        logic [ROB_POS_W-1:0] rob_pos;
        logic [31:0]          pc;
        logic [31:0]          imm;
        logic                 dep1;
        logic [ROB_POS_W-1:0] tag1;
        logic [31:0]          val1;
        logic                 dep2;
        logic [ROB_POS_W-1:0] tag2;
        logic [31:0]          val2;
    } entry_t;

    entry_t               ent [RS_SIZE];
    entry_t               nxt [RS_SIZE];
    logic [RS_SIZE-1:0]   busy_vec;
    logic [RS_SIZE-1:0]   ready_vec;
    logic                 sel_vld;
    logic [IDX_W-1:0]     sel_idx;
    logic                 alloc_vld;
    logic [IDX_W-1:0]     alloc_idx;

    // Resolve a pending operand against both result buses; returns {dep, val}.
    // The ROB hands out unique tags, so at most one bus can match.
    function automatic logic [32:0] snoop(input logic dep,
                                          input logic [ROB_POS_W-1:0] tag,
                                          input logic [31:0] val);
        if (dep && alu_broadcast_enable && tag == alu_broadcast_rob_pos)
            return {1'b0, alu_broadcast_val};
        if (dep && lsb_broadcast_enable && tag == lsb_broadcast_rob_pos)
            return {1'b0, lsb_broadcast_val};
        return {dep, val};
    endfunction

    // Per-entry status vectors, taken from registered state only.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent[i].busy;
            ready_vec[i] = ent[i].busy && !ent[i].dep1 && !ent[i].dep2;
        end
    end

    assign rs_full = &busy_vec;

    // Lowest-index ready entry (select) and lowest-index free entry (alloc).
    always_comb begin
        sel_vld   = 1'b0;
        sel_idx   = '0;
        alloc_vld = 1'b0;
        alloc_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
            if (!busy_vec[i]) begin
                alloc_vld = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
    end

    // Next entry state: wakeup, free the selected slot, write the new micro-op.
    // Alloc only targets non-busy slots and select only busy ones, so the two
    // never touch the same entry in one cycle.
    always_comb begin
        nxt = ent;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ent[i].busy) begin
                {nxt[i].dep1, nxt[i].val1} = snoop(ent[i].dep1, ent[i].tag1, ent[i].val1);
                {nxt[i].dep2, nxt[i].val2} = snoop(ent[i].dep2, ent[i].tag2, ent[i].val2);
            end
        end
        if (sel_vld)
            nxt[sel_idx].busy = 1'b0;
        if (issue_enable && alloc_vld) begin
            nxt[alloc_idx].busy    = 1'b1;
            nxt[alloc_idx].openum  = issue_openum;
            nxt[alloc_idx].rob_pos = issue_rob_pos;
            nxt[alloc_idx].pc      = issue_pc;
            nxt[alloc_idx].imm     = issue_imm;
            nxt[alloc_idx].tag1    = issue_rs1_tag;
            nxt[alloc_idx].tag2    = issue_rs2_tag;
            {nxt[alloc_idx].dep1, nxt[alloc_idx].val1} =
                snoop(issue_rs1_dep, issue_rs1_tag, issue_rs1_val);
            {nxt[alloc_idx].dep2, nxt[alloc_idx].val2} =
                snoop(issue_rs2_dep, issue_rs2_tag, issue_rs2_val);
        end
    end

    // Entry storage: reset, then flush, then freeze on !rdy, then update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++)
                ent[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < RS_SIZE; i++)
                ent[i].busy <= 1'b0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++)
                ent[i] <= nxt[i];
        end
    end

    // Registered ALU-side outputs; the data fields hold when nothing issues.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rs_to_alu_enable  <= 1'b0;
            rs_to_alu_openum  <= '0;
            rs_to_alu_rob_pos <= '0;
            rs_to_alu_rs1_val <= '0;
            rs_to_alu_rs2_val <= '0;
            rs_to_alu_imm     <= '0;
            rs_to_alu_pc      <= '0;
        end else if (clr) begin
            rs_to_alu_enable  <= 1'b0;
        end else if (rdy) begin
            rs_to_alu_enable  <= sel_vld;
            if (sel_vld) begin
                rs_to_alu_openum  <= ent[sel_idx].openum;
                rs_to_alu_rob_pos <= ent[sel_idx].rob_pos;
                rs_to_alu_rs1_val <= ent[sel_idx].val1;
                rs_to_alu_rs2_val <= ent[sel_idx].val2;
                rs_to_alu_imm     <= ent[sel_idx].imm;
                rs_to_alu_pc      <= ent[sel_idx].pc;
            end
        end
    end

endmodule
